// File: rtl/div_stage_if.sv
// -----------------------------------------------------------------------------
// div_stage_if
// Bundles the signals of the divider staging controller.
//
// Signal groups:
//   in_*        operand pair handshake (valid/ready) with signed dividend/divisor
//   div_*       FIFO head sent to an external combinational divider, and the
//               quotient/remainder it returns in the same cycle
//   out_*       registered result handshake: quotient, remainder, dbz/ovf flags
//
// Modports:
//   slave       the controller's view
//   master      the surrounding environment's view (producer, divider, consumer)
// -----------------------------------------------------------------------------
interface div_stage_if #(
   parameter int WIDTH = 8
);
   logic                    in_valid;
   logic                    in_ready;
   logic signed [WIDTH-1:0] in_dividend;
   logic signed [WIDTH-1:0] in_divisor;

   logic signed [WIDTH-1:0] div_dividend;
   logic signed [WIDTH-1:0] div_divisor;
   logic signed [WIDTH-1:0] div_quotient;
   logic signed [WIDTH-1:0] div_remainder;

   logic                    out_valid;
   logic                    out_ready;
   logic signed [WIDTH-1:0] out_quotient;
   logic signed [WIDTH-1:0] out_remainder;
   logic                    out_dbz;
   logic                    out_ovf;

   modport slave (
      input  in_valid, in_dividend, in_divisor,
      input  div_quotient, div_remainder,
      input  out_ready,
      output in_ready,
      output div_dividend, div_divisor,
      output out_valid, out_quotient, out_remainder, out_dbz, out_ovf
   );

   modport master (
      output in_valid, in_dividend, in_divisor,
      output div_quotient, div_remainder,
      output out_ready,
      input  in_ready,
      input  div_dividend, div_divisor,
      input  out_valid, out_quotient, out_remainder, out_dbz, out_ovf
   );
endinterface

// File: rtl/div_stage_ctrl.sv
// -----------------------------------------------------------------------------
// div_stage_ctrl
// Queues signed operand pairs in a small circular FIFO, presents the head to an
// external combinational divider, and registers its result (with divide-by-zero
// and overflow corner cases resolved locally) into a valid/ready output slot.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        div_stage_if.slave (operand input, divider link, result output)
//   dbz_count  16-bit saturating count of loaded divide-by-zero results  (*)
//   ovf_count  16-bit saturating count of loaded overflow results        (*)
//
// (*) present only when the macro DIV_STAGE_STATS_EN is defined.
// -----------------------------------------------------------------------------
module div_stage_ctrl #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   div_stage_if.slave  bus
`ifdef DIV_STAGE_STATS_EN
   ,
   output logic [15:0] dbz_count,
   output logic [15:0] ovf_count
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]             PTR_ONE   = {{AW{1'b0}}, 1'b1};
   localparam logic signed [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic signed [WIDTH-1:0] MINUS_ONE = '1;

   logic [AW:0]             wr_ptr_q, wr_ptr_d;
   logic [AW:0]             rd_ptr_q, rd_ptr_d;
   logic signed [WIDTH-1:0] mem_dvd_q [DEPTH];
   logic signed [WIDTH-1:0] mem_dvs_q [DEPTH];

   logic                    out_valid_q, out_valid_d;
   logic signed [WIDTH-1:0] out_quo_q, out_quo_d;
   logic signed [WIDTH-1:0] out_rem_q, out_rem_d;
   logic                    out_dbz_q, out_dbz_d;
   logic                    out_ovf_q, out_ovf_d;

   logic full, empty, push, load;
   logic is_dbz, is_ovf;

   always_comb begin
      empty = (wr_ptr_q == rd_ptr_q);
      // Same slot index but opposite wrap bit: writer is a full lap ahead.
      full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      push  = bus.in_valid && !full;
      load  = !empty && (!out_valid_q || bus.out_ready);
   end

   assign bus.in_ready     = !full;
   assign bus.div_dividend = empty ? '0 : mem_dvd_q[rd_ptr_q[AW-1:0]];
   assign bus.div_divisor  = empty ? '0 : mem_dvs_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      is_dbz = (bus.div_divisor == '0);
      is_ovf = !is_dbz && (bus.div_dividend == MOST_NEG) &&
               (bus.div_divisor == MINUS_ONE);
   end

   always_comb begin
      wr_ptr_d    = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d    = load ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      out_quo_d   = out_quo_q;
      out_rem_d   = out_rem_q;
      out_dbz_d   = out_dbz_q;
      out_ovf_d   = out_ovf_q;
      // A consumed slot empties unless it is refilled on the same edge.
      out_valid_d = load ? 1'b1 : (bus.out_ready ? 1'b0 : out_valid_q);
      if (load) begin
         out_dbz_d = is_dbz;
         out_ovf_d = is_ovf;
         if (is_dbz) begin
            // Divider output is meaningless here; force the defined result.
            out_quo_d = MINUS_ONE;
            out_rem_d = bus.div_dividend;
         end else if (is_ovf) begin
            out_quo_d = MOST_NEG;
            out_rem_d = '0;
         end else begin
            out_quo_d = bus.div_quotient;
            out_rem_d = bus.div_remainder;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_quo_q   <= '0;
         out_rem_q   <= '0;
         out_dbz_q   <= 1'b0;
         out_ovf_q   <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         out_valid_q <= out_valid_d;
         out_quo_q   <= out_quo_d;
         out_rem_q   <= out_rem_d;
         out_dbz_q   <= out_dbz_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   // Operand storage carries no reset; the pointers alone define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_dvd_q[wr_ptr_q[AW-1:0]] <= bus.in_dividend;
         mem_dvs_q[wr_ptr_q[AW-1:0]] <= bus.in_divisor;
      end
   end

   assign bus.out_valid     = out_valid_q;
   assign bus.out_quotient  = out_quo_q;
   assign bus.out_remainder = out_rem_q;
   assign bus.out_dbz       = out_dbz_q;
   assign bus.out_ovf       = out_ovf_q;

`ifdef DIV_STAGE_STATS_EN
   logic [15:0] dbz_cnt_q, dbz_cnt_d;
   logic [15:0] ovf_cnt_q, ovf_cnt_d;

   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   always_comb begin
      dbz_cnt_d = (load && is_dbz) ? sat_inc(dbz_cnt_q) : dbz_cnt_q;
      ovf_cnt_d = (load && is_ovf) ? sat_inc(ovf_cnt_q) : ovf_cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dbz_cnt_q <= '0;
         ovf_cnt_q <= '0;
      end else begin
         dbz_cnt_q <= dbz_cnt_d;
         ovf_cnt_q <= ovf_cnt_d;
      end
   end

   assign dbz_count = dbz_cnt_q;
   assign ovf_count = ovf_cnt_q;
`endif
endmodule

// File: tb/tb_div_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_stage_ctrl
// Scoreboard bench: accepted pairs push a model result, a monitor pops and
// compares on every output transfer. Also stands in for the external divider.
// -----------------------------------------------------------------------------
module tb_div_stage_ctrl;
   localparam int WIDTH = 8;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   div_stage_if #(.WIDTH(WIDTH)) bus ();

`ifdef DIV_STAGE_STATS_EN
   logic [15:0] dbz_count, ovf_count;
`endif

   div_stage_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef DIV_STAGE_STATS_EN
      ,
      .dbz_count (dbz_count),
      .ovf_count (ovf_count)
`endif
   );

   // Stand-in divider; corner cases return a junk pattern the DUT must override.
   always_comb begin
      bus.div_quotient  = 8'sh5A;
      bus.div_remainder = 8'sh5A;
      if (bus.div_divisor != 8'sd0 &&
          !(bus.div_dividend == 8'sh80 && bus.div_divisor == 8'shFF)) begin
         bus.div_quotient  = 8'(int'(bus.div_dividend) / int'(bus.div_divisor));
         bus.div_remainder = 8'(int'(bus.div_dividend) % int'(bus.div_divisor));
      end
   end

   typedef struct {int q; int r; int dbz; int ovf;} res_t;

   res_t exp_q[$];
   res_t got_log[$];
   int   got_cyc[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   bit   hold_pending = 1'b0;
   res_t hold_val;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic res_t model(input int a, input int b);
      res_t m;
      m.dbz = 0;
      m.ovf = 0;
      if (b == 0) begin
         m.q = -1; m.r = a; m.dbz = 1;
      end else if (a == -128 && b == -1) begin
         m.q = -128; m.r = 0; m.ovf = 1;
      end else begin
         m.q = a / b;
         m.r = a - m.q * b;
      end
      return m;
   endfunction

   function automatic res_t cur_out();
      res_t o;
      o.q   = int'(bus.out_quotient);
      o.r   = int'(bus.out_remainder);
      o.dbz = int'(bus.out_dbz);
      o.ovf = int'(bus.out_ovf);
      return o;
   endfunction

   // Scoreboard producer: record the expected result of every accepted pair.
   always @(negedge clk) begin
      if (rst_n && bus.in_valid && bus.in_ready)
         exp_q.push_back(model(int'(bus.in_dividend), int'(bus.in_divisor)));
   end

   // Monitor: compare transfers against the scoreboard and check hold stability.
   always @(negedge clk) begin
      res_t a, e;
      if (!rst_n) begin
         hold_pending = 1'b0;
      end else begin
         a = cur_out();
         if (hold_pending) begin
            chk("hold_valid", int'(bus.out_valid), 1);
            chk("hold_quotient", a.q, hold_val.q);
            chk("hold_remainder", a.r, hold_val.r);
            chk("hold_flags", a.dbz * 2 + a.ovf, hold_val.dbz * 2 + hold_val.ovf);
         end
         if (bus.out_valid && bus.out_ready) begin
            got_log.push_back(a);
            got_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("sb_quotient", a.q, e.q);
               chk("sb_remainder", a.r, e.r);
               chk("sb_dbz", a.dbz, e.dbz);
               chk("sb_ovf", a.ovf, e.ovf);
            end
         end
         hold_pending = bus.out_valid && !bus.out_ready;
         hold_val = a;
      end
   end

   task automatic push(input int a, input int b);
      int n;
      bit acc;
      bus.in_valid    = 1'b1;
      bus.in_dividend = 8'(a);
      bus.in_divisor  = 8'(b);
      n = 0;
      acc = 1'b0;
      do begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 50);
      if (!acc) chk("push_timeout", 0, 1);
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int n;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      n = 0;
      while ((exp_q.size() != 0 || bus.out_valid) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_queue_empty", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      got_log.delete();
      got_cyc.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
      chk({tag, "_in_ready"}, int'(bus.in_ready), 1);
      chk({tag, "_out_quotient"}, int'(bus.out_quotient), 0);
      chk({tag, "_out_remainder"}, int'(bus.out_remainder), 0);
      chk({tag, "_flags"}, int'(bus.out_dbz) + int'(bus.out_ovf), 0);
   endtask

   initial begin
      int a, b, sel;
      bus.in_valid    = 1'b0;
      bus.in_dividend = '0;
      bus.in_divisor  = '0;
      bus.out_ready   = 1'b1;

      #2;
      chk_reset_state("reset");
      do_reset();

      // Single pair: latency and basic quotient.
      idle(1);
      push(100, 7);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("latency_not_yet_valid", int'(bus.out_valid), 0);
      @(negedge clk);
      chk("latency_valid", int'(bus.out_valid), 1);
      chk("p100_7_quotient", int'(bus.out_quotient), 14);
      chk("p100_7_remainder", int'(bus.out_remainder), 2);
      chk("p100_7_flags", int'(bus.out_dbz) + int'(bus.out_ovf), 0);
      idle(2);

      // Back-to-back normal / divide-by-zero / overflow.
      got_log.delete();
      push(-100, 7);
      push(5, 0);
      push(-128, -1);
      drain();
      chk("b2b_count", got_log.size(), 3);
      if (got_log.size() == 3) begin
         chk("b2b0_q", got_log[0].q, -14);
         chk("b2b0_r", got_log[0].r, -2);
         chk("b2b0_flags", got_log[0].dbz * 2 + got_log[0].ovf, 0);
         chk("b2b1_q", got_log[1].q, -1);
         chk("b2b1_r", got_log[1].r, 5);
         chk("b2b1_dbz", got_log[1].dbz, 1);
         chk("b2b1_ovf", got_log[1].ovf, 0);
         chk("b2b2_q", got_log[2].q, -128);
         chk("b2b2_r", got_log[2].r, 0);
         chk("b2b2_dbz", got_log[2].dbz, 0);
         chk("b2b2_ovf", got_log[2].ovf, 1);
      end

      // Fill: one held plus DEPTH queued, then release.
      bus.out_ready = 1'b0;
      got_log.delete();
      got_cyc.delete();
      for (int i = 0; i < 5; i++) push(10 * (i + 1), 3);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("full_in_ready", int'(bus.in_ready), 0);
      chk("full_out_valid", int'(bus.out_valid), 1);
      @(posedge clk);
      #1;
      drain();
      chk("full_release_count", got_log.size(), 5);
      if (got_log.size() == 5) begin
         chk("full_release_back_to_back", got_cyc[4] - got_cyc[0], 4);
         chk("full_order_0", got_log[0].q, 3);
         chk("full_order_1", got_log[1].q, 6);
         chk("full_order_2", got_log[2].q, 10);
         chk("full_order_3", got_log[3].q, 13);
         chk("full_order_4", got_log[4].q, 16);
      end

      // Streaming 20 random pairs.
      idle(2);
      got_log.delete();
      got_cyc.delete();
      for (int i = 0; i < 20; i++) begin
         sel = int'($urandom_range(0, 7));
         a = int'($urandom_range(0, 255)) - 128;
         b = int'($urandom_range(0, 255)) - 128;
         if (sel == 0) b = 0;
         if (sel == 1) begin a = -128; b = -1; end
         push(a, b);
      end
      drain();
      chk("stream_count", got_log.size(), 20);
      if (got_log.size() == 20)
         chk("stream_consecutive", got_cyc[19] - got_cyc[0], 19);

      // Reset mid-operation.
      idle(2);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(i + 20, 3);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("pre_reset_out_valid", int'(bus.out_valid), 1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk_reset_state("midreset");
      exp_q.delete();
      got_log.delete();
      got_cyc.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      push(9, 2);
      drain();
      idle(5);
      chk("post_reset_count", got_log.size(), 1);
      if (got_log.size() == 1) begin
         chk("post_reset_q", got_log[0].q, 4);
         chk("post_reset_r", got_log[0].r, 1);
      end

      // Random traffic with random back-pressure.
      for (int i = 0; i < 400; i++) begin
         sel = int'($urandom_range(0, 9));
         bus.in_valid    = ($urandom_range(0, 3) != 0);
         bus.in_dividend = 8'($urandom_range(0, 255));
         bus.in_divisor  = 8'($urandom_range(0, 255));
         if (sel == 0) bus.in_divisor = 8'sd0;
         if (sel == 1) begin bus.in_dividend = 8'sh80; bus.in_divisor = 8'shFF; end
         bus.out_ready   = ($urandom_range(0, 2) != 0);
         @(posedge clk);
         #1;
      end
      drain();

`ifdef DIV_STAGE_STATS_EN
      do_reset();
      chk("stats_reset_dbz", int'(dbz_count), 0);
      chk("stats_reset_ovf", int'(ovf_count), 0);
      push(3, 0);
      push(7, 0);
      push(-5, 0);
      push(-128, -1);
      push(50, 5);
      drain();
      chk("stats_dbz_count", int'(dbz_count), 3);
      chk("stats_ovf_count", int'(ovf_count), 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
      $fatal(1);
   end
endmodule

// File: doc/div_stage_ctrl.md
DIV_STAGE_CTRL -- requirements
Module: div_stage_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand/result bit width, WIDTH >= 4.
REQ-002 Parameter DEPTH, default 4: operand FIFO entries, power of 2, DEPTH >= 2.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  FIFO can accept; a pair transfers on rising edge when in_valid && in_ready.
REQ-007 in_dividend, in_divisor  input  WIDTH each  signed two's-complement operands.
REQ-008 div_dividend, div_divisor  output  WIDTH each  FIFO head, driven combinationally to the downstream combinational divider; zero when FIFO empty.
REQ-009 div_quotient, div_remainder  input  WIDTH each  divider results for the current div_* operands, same cycle.
REQ-010 out_valid  output  1  result held.
REQ-011 out_ready  input  1  consumer accepts; a result transfers on rising edge when out_valid && out_ready.
REQ-012 out_quotient, out_remainder  output  WIDTH each  registered signed results.
REQ-013 out_dbz  output  1  registered divide-by-zero flag.
REQ-014 out_ovf  output  1  registered overflow flag.

Function
REQ-015 FIFO SHALL be circular, with read/write pointers one bit wider than log2(DEPTH); full when the pointers differ only in the MSB, empty when they are equal.
REQ-016 in_ready SHALL equal !full and SHALL NOT depend combinationally on out_ready.
REQ-017 Output load condition SHALL be !empty && (!out_valid || out_ready); on load, the FIFO SHALL pop and the output registers SHALL capture the head result.
REQ-018 When div_divisor == 0: out_quotient SHALL be all ones (-1), out_remainder SHALL be div_dividend, out_dbz = 1, out_ovf = 0, and div_quotient/div_remainder SHALL be ignored.
REQ-019 When div_dividend == most-negative and div_divisor == -1: out_quotient SHALL be most-negative, out_remainder SHALL be 0, out_ovf = 1, out_dbz = 0.
REQ-020 Otherwise out_quotient/out_remainder SHALL be div_quotient/div_remainder, with both flags 0.
REQ-021 Latency: a pair accepted at edge E into an empty FIFO with the output slot free SHALL appear with out_valid = 1 after edge E+1.
REQ-022 Throughput: one result per cycle sustained while in_valid and out_ready are held at 1.
REQ-023 While out_valid && !out_ready, all out_* signals SHALL hold stable.
REQ-024 out_valid SHALL clear on a transfer edge with no load; a transfer and a load on the same edge SHALL keep out_valid = 1 with new data.
REQ-025 A push and a pop on the same edge SHALL leave occupancy unchanged, including when the FIFO is full (push blocked by in_ready) or empty (no pop).
REQ-026 Results SHALL emerge in acceptance order; none SHALL be dropped or duplicated.

Reset
REQ-027 rst_n low SHALL immediately clear the pointers, out_valid, out_quotient, out_remainder, out_dbz and out_ovf to 0; in_ready SHALL read 1 while in reset.
REQ-028 Reset mid-operation SHALL discard all queued pairs and any held result; the first post-reset acceptance SHALL behave as for an empty block.
REQ-029 FIFO storage contents need not be reset.

Configuration
REQ-030 With DIV_STAGE_STATS_EN defined, outputs dbz_count and ovf_count (16 bits each) SHALL exist, incrementing on each loaded result with the matching flag, saturating at 0xFFFF, and clearing on reset.
REQ-031 Without DIV_STAGE_STATS_EN, those ports and counters SHALL be absent, with no other behavioural change.

Verification
REQ-032 WIDTH=8: push (100, 7) with out_ready=1 -> one cycle later out_quotient=14, out_remainder=2, flags 0.
REQ-033 Push (-100, 7), then (5, 0), then (-128, -1) back-to-back -> in order: (-14, -2, 0, 0), (-1, 5, dbz=1), (-128, 0, ovf=1).
REQ-034 out_ready=0, push 5 pairs with DEPTH=4 -> one result held, 4 queued, in_ready=0; raise out_ready -> all 5 emerge in order, 1 per cycle.
REQ-035 Streaming 20 random pairs with in_valid=1 and out_ready=1 -> 20 results on 20 consecutive cycles, each matching a model.
REQ-036 Assert rst_n=0 with 3 entries queued and out_valid=1 -> out_valid=0 and in_ready=1 immediately; the next push yields only its own result.
REQ-037 With DIV_STAGE_STATS_EN defined: 3 divide-by-zero pairs and 1 overflow pair -> dbz_count=3, ovf_count=1.
